// File: rtl/minn_pkg.sv
// Shared types and constants for the Minn preamble generator.
//   minn_gen_state_t : generator FSM states (IDLE, QUARTER, GAP)
//   NUM_QUARTERS     : quarters per preamble
//   SIGN_MASK        : bit k set means quarter k is emitted negated ([A A -A -A])
package minn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUARTER = 2'd1,
    GAP     = 2'd2
  } minn_gen_state_t;

  localparam int         NUM_QUARTERS = 4;
  localparam logic [3:0] SIGN_MASK    = 4'b1100;

endpackage

// File: rtl/minn_pattern_ram.sv
// Pattern store for one preamble quarter: simple dual-port RAM with a registered
// read port and no reset.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data ({I, Q})
//   rd_en   : read strobe; rd_data holds its value while low
//   rd_addr : read address
//   rd_data : read data, valid the cycle after rd_en
module minn_pattern_ram #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read port; a same-cycle write to the read address is forwarded so a write
  // issued alongside start is what the burst's first read sees.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/minn_preamble_gen.sv
// Minn timing-sync preamble generator: emits [A A -A -A] from a programmable
// QUARTER_LEN-sample pattern, followed by GAP_LEN zero samples, on a
// valid/ready stream.
//   clk, rst                        : clock, synchronous active-high reset
//   pat_wr_en/addr/i/q              : pattern write port (dropped while busy)
//   start                           : request one preamble (accepted when !busy)
//   busy                            : burst in progress
//   out_valid/out_ready             : output handshake
//   out_i, out_q, out_last          : output sample and end-of-burst marker
//   done                            : 1-cycle pulse after the final handshake
module minn_preamble_gen
  import minn_pkg::*;
#(
  parameter int INPUT_WIDTH = 12,
  parameter int QUARTER_LEN = 512,
  parameter int GAP_LEN     = 0,
  parameter int ADDR_WIDTH  = $clog2(QUARTER_LEN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pat_wr_en,
  input  logic [ADDR_WIDTH-1:0]  pat_wr_addr,
  input  logic [INPUT_WIDTH-1:0] pat_wr_i,
  input  logic [INPUT_WIDTH-1:0] pat_wr_q,
  input  logic                   start,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INPUT_WIDTH-1:0] out_i,
  output logic [INPUT_WIDTH-1:0] out_q,
  output logic                   out_last,
  output logic                   done
);

  localparam int GAP_WIDTH = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST    = ADDR_WIDTH'(QUARTER_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE     = ADDR_WIDTH'(1);
  localparam logic [GAP_WIDTH-1:0]  GAP_LAST     = GAP_WIDTH'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam logic [GAP_WIDTH-1:0]  GAP_ONE      = GAP_WIDTH'(1);
  localparam logic [1:0]            QUARTER_LAST = 2'(NUM_QUARTERS - 1);
  localparam logic [1:0]            QUARTER_ONE  = 2'd1;

  // Two's complement negate with the most negative code clamped to the most positive.
  function automatic logic [INPUT_WIDTH-1:0] sat_neg(input logic [INPUT_WIDTH-1:0] x);
    logic [INPUT_WIDTH-1:0] most_neg;
    most_neg = {1'b1, {(INPUT_WIDTH-1){1'b0}}};
    if (x == most_neg) begin
      sat_neg = ~most_neg;
    end else begin
      sat_neg = -x;
    end
  endfunction

  minn_gen_state_t state_r, state_nxt_s;
  logic busy_r, done_r, busy_nxt_s, done_nxt_s;
  logic start_acc_s, wr_en_s, hs_s;

  // Fetch side: walks q/a (and the gap counter) ahead of the output stage.
  logic                   fetch_active_r, fgap_r;
  logic [1:0]             fq_r;
  logic [ADDR_WIDTH-1:0]  fa_r;
  logic [GAP_WIDTH-1:0]   fg_r;
  logic                   fetch_go_s, f_qend_s, f_last_s, f_neg_s;

  // Stage 1: RAM read data plus the tags of the sample being read.
  logic                   s1_valid_r, s1_neg_r, s1_gap_r, s1_qend_r, s1_last_r, s1_move_s;
  logic [2*INPUT_WIDTH-1:0] ram_rd_data_s;
  logic [INPUT_WIDTH-1:0] s1_i_s, s1_q_s;

  // Output register.
  logic                   out_valid_r, out_last_r, out_qend_r;
  logic [INPUT_WIDTH-1:0] out_i_r, out_q_r;

  assign start_acc_s = start && !busy_r;
  assign wr_en_s     = pat_wr_en && !busy_r;
  assign hs_s        = out_valid_r && out_ready;
  assign s1_move_s   = s1_valid_r && (!out_valid_r || out_ready);
  // First read is issued in the start cycle itself so data reaches the output at N+2.
  assign fetch_go_s  = (start_acc_s || fetch_active_r) && (!s1_valid_r || s1_move_s);
  assign f_qend_s    = !fgap_r && (fq_r == QUARTER_LAST) && (fa_r == ADDR_LAST);
  assign f_last_s    = fgap_r ? (fg_r == GAP_LAST) : (f_qend_s && (GAP_LEN == 0));
  assign f_neg_s     = !fgap_r && SIGN_MASK[fq_r];

  minn_pattern_ram #(
    .DATA_WIDTH (2*INPUT_WIDTH),
    .DEPTH      (QUARTER_LEN),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (pat_wr_addr),
    .wr_data ({pat_wr_i, pat_wr_q}),
    .rd_en   (fetch_go_s),
    .rd_addr (fa_r),
    .rd_data (ram_rd_data_s)
  );

  // FSM state register and registered busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // FSM next state, advanced by output handshakes.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_acc_s) begin
          state_nxt_s = QUARTER;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      QUARTER: begin
        if (hs_s && out_qend_r) begin
          state_nxt_s = (GAP_LEN > 0) ? GAP : IDLE;
        end else begin
          state_nxt_s = QUARTER;
        end
      end
      GAP: begin
        if (hs_s && out_last_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GAP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: busy while not idle, done on the return to idle.
  always_comb begin
    busy_nxt_s = (state_nxt_s != IDLE);
    done_nxt_s = (state_r != IDLE) && (state_nxt_s == IDLE);
  end

  // Fetch counters: a wraps at QUARTER_LEN-1 and bumps q; gap counter follows q3.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_active_r <= 1'b0;
      fgap_r         <= 1'b0;
      fq_r           <= 2'd0;
      fa_r           <= '0;
      fg_r           <= '0;
    end else if (fetch_go_s) begin
      fetch_active_r <= !f_last_s;
      if (fgap_r) begin
        if (fg_r == GAP_LAST) begin
          fg_r   <= '0;
          fgap_r <= 1'b0;
        end else begin
          fg_r <= fg_r + GAP_ONE;
        end
      end else if (fa_r == ADDR_LAST) begin
        fa_r <= '0;
        if (fq_r == QUARTER_LAST) begin
          fq_r   <= 2'd0;
          fgap_r <= (GAP_LEN > 0);
        end else begin
          fq_r <= fq_r + QUARTER_ONE;
        end
      end else begin
        fa_r <= fa_r + ADDR_ONE;
      end
    end
  end

  // Stage 1 valid and tags; RAM data holds while the stage is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_neg_r   <= 1'b0;
      s1_gap_r   <= 1'b0;
      s1_qend_r  <= 1'b0;
      s1_last_r  <= 1'b0;
    end else if (fetch_go_s) begin
      s1_valid_r <= 1'b1;
      s1_neg_r   <= f_neg_s;
      s1_gap_r   <= fgap_r;
      s1_qend_r  <= f_qend_s;
      s1_last_r  <= f_last_s;
    end else if (s1_move_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Sample value for stage 1: zero in the gap, saturating negate in quarters 2-3.
  always_comb begin
    s1_i_s = ram_rd_data_s[2*INPUT_WIDTH-1:INPUT_WIDTH];
    s1_q_s = ram_rd_data_s[INPUT_WIDTH-1:0];
    if (s1_gap_r) begin
      s1_i_s = '0;
      s1_q_s = '0;
    end else if (s1_neg_r) begin
      s1_i_s = sat_neg(ram_rd_data_s[2*INPUT_WIDTH-1:INPUT_WIDTH]);
      s1_q_s = sat_neg(ram_rd_data_s[INPUT_WIDTH-1:0]);
    end else begin
      s1_i_s = ram_rd_data_s[2*INPUT_WIDTH-1:INPUT_WIDTH];
      s1_q_s = ram_rd_data_s[INPUT_WIDTH-1:0];
    end
  end

  // Output register: loads from stage 1 when empty or being consumed, else holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_qend_r  <= 1'b0;
      out_i_r     <= '0;
      out_q_r     <= '0;
    end else if (s1_move_s) begin
      out_valid_r <= 1'b1;
      out_last_r  <= s1_last_r;
      out_qend_r  <= s1_qend_r;
      out_i_r     <= s1_i_s;
      out_q_r     <= s1_q_s;
    end else if (hs_s) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_qend_r  <= 1'b0;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_i     = out_i_r;
  assign out_q     = out_q_r;

endmodule

// File: tb/tb_minn_preamble_gen.sv
`timescale 1ns/1ps
// Bench for minn_preamble_gen: two instances (GAP_LEN=0 and GAP_LEN=3) sharing the
// clock and data buses; dsel picks which one is driven and observed.
module tb_minn_preamble_gen;

  localparam int W  = 12;
  localparam int QL = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pat_wr_addr;
  logic [W-1:0]  pat_wr_i, pat_wr_q;
  logic          out_ready, start_b, we_b, dsel;

  logic          busy0, valid0, last0, done0, busy1, valid1, last1, done1;
  logic [W-1:0]  i0, q0, i1, q1;
  logic          m_busy, m_valid, m_last, m_done;
  logic [W-1:0]  m_i, m_q;

  int n_checks = 0;
  int n_fail   = 0;
  int mp_i [2][QL];
  int mp_q [2][QL];
  int base_i [QL] = '{1, 2, 3, 4};
  int base_q [QL] = '{-1, 0, 5, -7};

  always #5 clk = ~clk;

  assign m_busy  = dsel ? busy1  : busy0;
  assign m_valid = dsel ? valid1 : valid0;
  assign m_last  = dsel ? last1  : last0;
  assign m_done  = dsel ? done1  : done0;
  assign m_i     = dsel ? i1     : i0;
  assign m_q     = dsel ? q1     : q0;

  minn_preamble_gen #(.INPUT_WIDTH(W), .QUARTER_LEN(QL), .GAP_LEN(0)) u_dut (
    .clk(clk), .rst(rst), .pat_wr_en(we_b & ~dsel), .pat_wr_addr(pat_wr_addr),
    .pat_wr_i(pat_wr_i), .pat_wr_q(pat_wr_q), .start(start_b & ~dsel), .busy(busy0),
    .out_valid(valid0), .out_ready(out_ready), .out_i(i0), .out_q(q0),
    .out_last(last0), .done(done0));

  minn_preamble_gen #(.INPUT_WIDTH(W), .QUARTER_LEN(QL), .GAP_LEN(3)) u_dut_gap (
    .clk(clk), .rst(rst), .pat_wr_en(we_b & dsel), .pat_wr_addr(pat_wr_addr),
    .pat_wr_i(pat_wr_i), .pat_wr_q(pat_wr_q), .start(start_b & dsel), .busy(busy1),
    .out_valid(valid1), .out_ready(out_ready), .out_i(i1), .out_q(q1),
    .out_last(last1), .done(done1));

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int neg_sat(input int x);
    int r;
    r = -x;
    if (r > 2047) r = 2047;
    return r;
  endfunction

  function automatic int rand_sample();
    return int'($urandom_range(4095)) - 2048;
  endfunction

  // Write one pattern sample while idle; upd keeps the model in step.
  task automatic write_pat(input int a, input int vi, input int vq);
    @(posedge clk); #1;
    pat_wr_addr = a[AW-1:0];
    pat_wr_i    = vi[W-1:0];
    pat_wr_q    = vq[W-1:0];
    we_b        = 1'b1;
    mp_i[dsel][a] = vi;
    mp_q[dsel][a] = vq;
    @(posedge clk); #1;
    we_b = 1'b0;
  endtask

  // Run one burst. mode 0: ready=1, 1: 1010 toggle with a 5-cycle stall, 2: random ready.
  task automatic run_burst(input int mode, input bit pre_started, input bit chain,
                           input bit ign_start, input bit busy_wr, input int rst_at,
                           input bit wr_with_start);
    int exp_i[$], exp_q[$], exp_l[$];
    int rx_i[$], rx_q[$], rx_l[$];
    int gl, n, it, first_valid, first_hs, last_hs, stall_left, rst_phase, vi, vq;
    bit fin, last_seen, stalled, prev_stall;
    int prev_i, prev_q, prev_l;
    if (!pre_started) begin
      @(posedge clk); #1;
      start_b = 1'b1;
      if (wr_with_start) begin
        vi = rand_sample(); vq = rand_sample();
        pat_wr_addr = '0; pat_wr_i = vi[W-1:0]; pat_wr_q = vq[W-1:0]; we_b = 1'b1;
        mp_i[dsel][0] = vi; mp_q[dsel][0] = vq;
      end
    end
    @(posedge clk); #1;
    start_b = 1'b0;
    we_b    = 1'b0;
    gl = dsel ? 3 : 0;
    n  = 4*QL + gl;
    for (int k = 0; k < n; k++) begin
      if (k < 4*QL) begin
        vi = mp_i[dsel][k % QL];
        vq = mp_q[dsel][k % QL];
        if (k / QL >= 2) begin vi = neg_sat(vi); vq = neg_sat(vq); end
      end else begin
        vi = 0; vq = 0;
      end
      exp_i.push_back(vi); exp_q.push_back(vq); exp_l.push_back(k == n-1);
    end
    it = 0; fin = 0; last_seen = 0; stalled = 0; prev_stall = 0; stall_left = 0;
    first_valid = -1; first_hs = -1; last_hs = -1; rst_phase = 0;
    prev_i = 0; prev_q = 0; prev_l = 0;
    while (!fin && it < 200) begin
      start_b = chain && last_seen;
      we_b    = 1'b0;
      if (ign_start && it == 4) start_b = 1'b1;
      if (busy_wr && it == 6) begin
        pat_wr_addr = 2'd2; pat_wr_i = 12'h123; pat_wr_q = 12'h456; we_b = 1'b1;
      end
      if (rst_phase == 1) begin rst = 1'b0; rst_phase = 2; end
      if (rst_at >= 0 && rst_phase == 0 && rx_i.size() == rst_at) begin
        rst = 1'b1; rst_phase = 1;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: begin
          if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
          else if (!stalled && rx_i.size() == 5) begin
            stalled = 1; stall_left = 4; out_ready = 1'b0;
          end else out_ready = ~out_ready;
        end
        default: out_ready = ($urandom_range(3) != 0);
      endcase
      @(negedge clk);
      if (rst_phase == 2) begin
        check_val("rst_valid", m_valid, 0);
        check_val("rst_busy", m_busy, 0);
        check_val("rst_done", m_done, 0);
        fin = 1;
      end else begin
        if (it == 0) begin
          check_val("lat_busy", m_busy, 1);
          check_val("lat_valid_early", m_valid, 0);
        end
        if (m_valid && first_valid < 0) first_valid = it;
        if (prev_stall) begin
          check_val("hold_valid", m_valid, 1);
          check_val("hold_i", int'($signed(m_i)), prev_i);
          check_val("hold_q", int'($signed(m_q)), prev_q);
          check_val("hold_last", m_last, prev_l);
        end
        if (last_seen) begin
          check_val("done_pulse", m_done, 1);
          check_val("busy_fall", m_busy, 0);
          fin = 1;
        end else begin
          check_val("done_early", m_done, 0);
          if (m_valid && out_ready) begin
            rx_i.push_back(int'($signed(m_i)));
            rx_q.push_back(int'($signed(m_q)));
            rx_l.push_back(int'(m_last));
            if (first_hs < 0) first_hs = it;
            last_hs = it;
            if (m_last) last_seen = 1;
          end
        end
        prev_stall = m_valid && !out_ready;
        prev_i = int'($signed(m_i)); prev_q = int'($signed(m_q)); prev_l = int'(m_last);
      end
      it++;
      if (!fin) begin @(posedge clk); #1; end
    end
    check_val("burst_end", fin, 1);
    if (rst_at < 0) begin
      check_val("first_valid_cycle", first_valid, 1);
      check_val("beats", rx_i.size(), n);
      for (int k = 0; k < n && k < rx_i.size(); k++) begin
        check_val($sformatf("i[%0d]", k), rx_i[k], exp_i[k]);
        check_val($sformatf("q[%0d]", k), rx_q[k], exp_q[k]);
        check_val($sformatf("last[%0d]", k), rx_l[k], exp_l[k]);
      end
      if (mode == 0) check_val("contiguous", last_hs - first_hs, n - 1);
    end
  endtask

  task automatic check_idle(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_val("idle_busy", m_busy, 0);
      check_val("idle_valid", m_valid, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start_b = 1'b0; we_b = 1'b0; dsel = 1'b0; out_ready = 1'b0;
    pat_wr_addr = '0; pat_wr_i = '0; pat_wr_q = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_busy", busy0, 0);
    check_val("reset_valid", valid0, 0);
    check_val("reset_last", last0, 0);
    check_val("reset_done", done0, 0);
    check_val("reset_i", int'(i0), 0);
    check_val("reset_q", int'(q0), 0);
    check_val("reset_gap_busy", busy1, 0);
    check_val("reset_gap_valid", valid1, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic burst.
    for (int a = 0; a < QL; a++) write_pat(a, base_i[a], base_q[a]);
    run_burst(0, 0, 0, 0, 0, -1, 0);

    // Saturation at a=0.
    write_pat(0, -2048, 2047);
    run_burst(0, 0, 0, 0, 0, -1, 0);

    // Backpressure with an ignored start mid-burst, then stay idle.
    write_pat(0, base_i[0], base_q[0]);
    run_burst(1, 0, 0, 1, 0, -1, 0);
    check_idle(3);

    // Dropped write while busy, start in the done cycle, second full burst.
    run_burst(0, 0, 1, 0, 1, -1, 0);
    run_burst(0, 1, 0, 0, 0, -1, 0);
    check_idle(2);

    // Reset mid-q2, then a full replay with the retained pattern.
    run_burst(0, 0, 0, 0, 0, 9, 0);
    run_burst(0, 0, 0, 0, 0, -1, 0);

    // Random patterns and ready, including a write alongside start.
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < QL; a++) write_pat(a, rand_sample(), rand_sample());
      run_burst(2, 0, 0, 0, 0, -1, r[0]);
    end

    // GAP_LEN=3 instance.
    dsel = 1'b1;
    for (int a = 0; a < QL; a++) write_pat(a, base_i[a], base_q[a]);
    run_burst(0, 0, 0, 0, 0, -1, 0);
    for (int a = 0; a < QL; a++) write_pat(a, rand_sample(), rand_sample());
    run_burst(2, 0, 0, 0, 0, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
